event_pulse_stretcher: RTL
==========================

# event_pulse_stretcher

Output-side counterpart of the button debouncer: the debouncer filters short, noisy input activity into clean levels, and this block turns single-cycle internal events (paddle hit, score, wall bounce) into long, clean, visibly separated output pulses for an LED or buzzer. Each accepted event produces exactly one high pulse of fixed width followed by a mandatory low gap. Events arriving while a pulse is in progress are queued in a saturating counter and replayed back-to-back, so every event up to the queue depth is rendered as a distinct pulse. The block sits between the game logic and the board's indicator/buzzer pins.

## Interface
- ON_WIDTH_IN_CLOCKS, 25_000_000, number of cycles the output is held high per event; must be >= 1.
- GAP_WIDTH_IN_CLOCKS, 12_500_000, minimum number of low cycles after every pulse; must be >= 1.
- MAX_PENDING, 3, queue depth for events not yet rendered; must be >= 1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- event_strobe  input  1  single-cycle event request, sampled on rising clk.
- stretched_out  output  1  registered pulse output to the pin.
- busy  output  1  high whenever state is not IDLE.
- pending_count  output  $clog2(MAX_PENDING+1)  number of queued, not-yet-started pulses.
- dropped_event  output  1  one-cycle strobe, high in the cycle after an event is discarded.

## Operation
- States: IDLE, ON, GAP. Cycle counter width $clog2(max(ON_WIDTH_IN_CLOCKS, GAP_WIDTH_IN_CLOCKS)+1); cleared on every state entry.
- IDLE: event_strobe=1 -> ON. Otherwise remain in IDLE.
- ON: stretched_out=1. After exactly ON_WIDTH_IN_CLOCKS cycles in ON -> GAP.
- GAP: stretched_out=0. After exactly GAP_WIDTH_IN_CLOCKS cycles in GAP: if event_strobe=1 in that final cycle -> ON, with pending_count unchanged. Otherwise, if pending_count>0 -> ON with pending_count-1. Otherwise -> IDLE.
- event_strobe=1 in ON or GAP (other than the final GAP cycle): pending_count+1 if pending_count<MAX_PENDING. Otherwise the event is discarded, pending_count stays at MAX_PENDING, and dropped_event pulses.
- A held-high event_strobe counts as one event per cycle; upstream must supply single-cycle strobes.
- stretched_out, busy, pending_count and dropped_event are all registered; none is combinational from event_strobe.
- Reset (async, any state): state=IDLE, counter=0, stretched_out=0, busy=0, pending_count=0, dropped_event=0. Events while rst=1 are ignored. Reset mid-pulse truncates the pulse immediately, and queued events are lost.

## Timing
- Latency: event_strobe sampled at the edge ending cycle N (from IDLE) -> stretched_out=1 from cycle N+1 through N+ON_WIDTH_IN_CLOCKS. Low for GAP_WIDTH_IN_CLOCKS cycles after that. busy=1 from N+1 through N+ON+GAP.
- Back-to-back queued pulses: a high period of exactly ON cycles, then a low period of exactly GAP cycles, with no idle cycle inserted.
- pending_count updates in the cycle after the event or the replay decision. dropped_event is high for exactly one cycle per discarded event.

## Configuration
- Macro EVENT_PULSE_STRETCHER_QUEUE_EN.
- Defined: pending queue behaves as described above.
- Undefined: the queue is not built and pending_count is tied to 0. Every event_strobe in ON or GAP, including the final GAP cycle, is discarded with a dropped_event pulse. Only events seen in IDLE start a pulse.

## Test plan
Parameters for all scenarios: ON=4, GAP=2, MAX_PENDING=3, macro defined unless stated.
- Single event at cycle 10 -> stretched_out high in cycles 11-14, low from 15; busy high 11-16, low at 17; pending_count stays 0.
- Event at 10, then events at 12, 13 and 14 -> four pulses at 11-14, 17-20, 23-26 and 29-32; pending_count peaks at 3 and reaches 0 at 17+6·2=29; dropped_event never asserts.
- Event at 10, then five events at 11-15 -> pending_count saturates at 3; dropped_event high in 2 cycles; four pulses total.
- Event at 10, second event in cycle 16 (last GAP cycle) -> second pulse in 17-20, no idle cycle between; pending_count stays 0.
- Event at 10, rst asserted mid-cycle 12 with 2 events queued -> stretched_out, busy and pending_count go to 0 without waiting for clk; no pulses after rst deasserts until a new event arrives.
- Macro undefined, events at 10 and 12 -> one pulse in 11-14; dropped_event high in cycle 13; pending_count stays 0.

Source files
------------

// File: rtl/event_pulse_stretcher.sv
// event_pulse_stretcher
// Turns single-cycle internal events into long, clean output pulses of fixed
// width, each followed by a mandatory low gap. Events that arrive while a pulse
// is running are queued in a saturating counter and replayed back-to-back.
//
// Optional feature macro: EVENT_PULSE_STRETCHER_QUEUE_EN
//   defined   -> pending queue built; busy-time events are queued up to MAX_PENDING
//   undefined -> no queue; pending_count tied to 0; every busy-time event dropped
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   event_strobe   single-cycle event request
//   stretched_out  registered pulse output
//   busy           registered, high whenever not idle
//   pending_count  registered count of queued, not-yet-started pulses
//   dropped_event  registered one-cycle strobe after a discarded event
module event_pulse_stretcher #(
  parameter int unsigned ON_WIDTH_IN_CLOCKS  = 25_000_000,
  parameter int unsigned GAP_WIDTH_IN_CLOCKS = 12_500_000,
  parameter int unsigned MAX_PENDING         = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 event_strobe,
  output logic                                 stretched_out,
  output logic                                 busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]     pending_count,
  output logic                                 dropped_event
);

  localparam int unsigned CNT_MAX = (ON_WIDTH_IN_CLOCKS > GAP_WIDTH_IN_CLOCKS) ?
                                    ON_WIDTH_IN_CLOCKS : GAP_WIDTH_IN_CLOCKS;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned PW = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            drop_d;
  logic            busy_event_c;
  logic            last_on_c, last_gap_c;

`ifdef EVENT_PULSE_STRETCHER_QUEUE_EN
  logic [PW-1:0]   pend_q, pend_d;
  assign pending_count = pend_q;
`else
  assign pending_count = PW'(0);
`endif

  assign last_on_c  = (cnt_q == CW'(ON_WIDTH_IN_CLOCKS - 1));
  assign last_gap_c = (cnt_q == CW'(GAP_WIDTH_IN_CLOCKS - 1));

  // Next-state, counter, queue and drop decisions
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    drop_d       = 1'b0;
    busy_event_c = 1'b0;
`ifdef EVENT_PULSE_STRETCHER_QUEUE_EN
    pend_d       = pend_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (event_strobe) state_d = ON;
      end

      ON: begin
        busy_event_c = event_strobe;
        if (last_on_c) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end

      GAP: begin
        if (last_gap_c) begin
          cnt_d = '0;
`ifdef EVENT_PULSE_STRETCHER_QUEUE_EN
          // A fresh event here starts the next pulse directly, leaving the queue alone
          if (event_strobe) begin
            state_d = ON;
          end else if (pend_q != PW'(0)) begin
            state_d = ON;
            pend_d  = pend_q - PW'(1);
          end else begin
            state_d = IDLE;
          end
`else
          busy_event_c = event_strobe;
          state_d      = IDLE;
`endif
        end else begin
          busy_event_c = event_strobe;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Events seen while busy: queue if room, otherwise discard
`ifdef EVENT_PULSE_STRETCHER_QUEUE_EN
    if (busy_event_c) begin
      if (pend_q < PW'(MAX_PENDING)) pend_d = pend_q + PW'(1);
      else                           drop_d = 1'b1;
    end
`else
    if (busy_event_c) drop_d = 1'b1;
`endif
  end

  // State and registered outputs; outputs follow the next state so they line up
  // with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stretched_out <= 1'b0;
      busy          <= 1'b0;
      dropped_event <= 1'b0;
`ifdef EVENT_PULSE_STRETCHER_QUEUE_EN
      pend_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stretched_out <= (state_d == ON);
      busy          <= (state_d != IDLE);
      dropped_event <= drop_d;
`ifdef EVENT_PULSE_STRETCHER_QUEUE_EN
      pend_q        <= pend_d;
`endif
    end
  end

endmodule
